// File: rtl/rs_alu_pkg.sv
// rs_alu_pkg: shared CPU sizes and the 5-bit ALU op encoding.
package rs_alu_pkg;
  localparam int ROB_SIZE_WIDTH = 4;
  localparam int RS_SIZE = 8;
  typedef logic [4:0] alu_op_t;
  localparam alu_op_t OP_ADD  = 5'h00;
  localparam alu_op_t OP_SUB  = 5'h08;
  localparam alu_op_t OP_SLL  = 5'h01;
  localparam alu_op_t OP_SLT  = 5'h02;
  localparam alu_op_t OP_SLTU = 5'h03;
  localparam alu_op_t OP_XOR  = 5'h04;
  localparam alu_op_t OP_SRL  = 5'h05;
  localparam alu_op_t OP_SRA  = 5'h0d;
  localparam alu_op_t OP_OR   = 5'h06;
  localparam alu_op_t OP_AND  = 5'h07;
  localparam alu_op_t OP_BEQ  = 5'h10;
  localparam alu_op_t OP_BNE  = 5'h11;
  localparam alu_op_t OP_BLT  = 5'h14;
  localparam alu_op_t OP_BGE  = 5'h15;
  localparam alu_op_t OP_BLTU = 5'h16;
  localparam alu_op_t OP_BGEU = 5'h17;
endpackage

// File: rtl/rs_find_first.sv
// rs_find_first: lowest-index priority encoder with a found flag.
module rs_find_first
  import rs_alu_pkg::*;
#(
  parameter int N = RS_SIZE,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);
  assign found = |req;
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? W'(i) : idx;
  end
endmodule

// File: rtl/rs_alu.sv
// rs_alu: ALU reservation station with CDB wakeup/bypass and single in-order-priority issue.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int RS_SIZE = rs_alu_pkg::RS_SIZE,
  parameter int ROB_SIZE_WIDTH = rs_alu_pkg::ROB_SIZE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      dispatch_valid,
  input  alu_op_t                   dispatch_op,
  input  logic [ROB_SIZE_WIDTH-1:0] dispatch_rob_id,
  input  logic [31:0]               dispatch_v1,
  input  logic [31:0]               dispatch_v2,
  input  logic                      dispatch_p1,
  input  logic                      dispatch_p2,
  input  logic [ROB_SIZE_WIDTH-1:0] dispatch_q1,
  input  logic [ROB_SIZE_WIDTH-1:0] dispatch_q2,
  input  logic                      cdb_alu_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_alu_rob_id,
  input  logic [31:0]               cdb_alu_result,
  input  logic                      cdb_lsb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_lsb_rob_id,
  input  logic [31:0]               cdb_lsb_result,
  output logic                      full,
  output logic                      issue_valid,
  output alu_op_t                   issue_op,
  output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  output logic [31:0]               issue_v1,
  output logic [31:0]               issue_v2
);
  localparam int IW = $clog2(RS_SIZE);
  localparam int RW = ROB_SIZE_WIDTH;
  logic [RS_SIZE-1:0] busy_q, busy_d, p1_q, p1_d, p2_q, p2_d;
  alu_op_t op_q [RS_SIZE];
  alu_op_t op_d [RS_SIZE];
  logic [RW-1:0] rob_q [RS_SIZE];
  logic [RW-1:0] rob_d [RS_SIZE];
  logic [RW-1:0] q1_q [RS_SIZE];
  logic [RW-1:0] q1_d [RS_SIZE];
  logic [RW-1:0] q2_q [RS_SIZE];
  logic [RW-1:0] q2_d [RS_SIZE];
  logic [31:0] v1_q [RS_SIZE];
  logic [31:0] v1_d [RS_SIZE];
  logic [31:0] v2_q [RS_SIZE];
  logic [31:0] v2_d [RS_SIZE];
  logic issue_valid_q, issue_valid_d;
  alu_op_t issue_op_q, issue_op_d;
  logic [RW-1:0] issue_rob_id_q, issue_rob_id_d;
  logic [31:0] issue_v1_q, issue_v1_d, issue_v2_q, issue_v2_d;
  logic [IW-1:0] free_idx, sel_idx;
  logic free_found, sel_found;

  rs_find_first #(.N(RS_SIZE)) u_free (.req(~busy_q), .idx(free_idx), .found(free_found));
  rs_find_first #(.N(RS_SIZE)) u_sel (.req(busy_q & ~p1_q & ~p2_q), .idx(sel_idx), .found(sel_found));

  assign full = !free_found;
  assign issue_valid = issue_valid_q;
  assign issue_op = issue_op_q;
  assign issue_rob_id = issue_rob_id_q;
  assign issue_v1 = issue_v1_q;
  assign issue_v2 = issue_v2_q;

  // Returns {pending, value}; the ALU CDB wins when both buses carry the tag.
  function automatic logic [32:0] wake(input logic p, input logic [RW-1:0] q, input logic [31:0] v);
    wake = !p ? {1'b0, v}
         : (cdb_alu_valid && cdb_alu_rob_id == q) ? {1'b0, cdb_alu_result}
         : (cdb_lsb_valid && cdb_lsb_rob_id == q) ? {1'b0, cdb_lsb_result}
         : {1'b1, v};
  endfunction

  always_comb begin
    busy_d = busy_q;
    p1_d = p1_q;
    p2_d = p2_q;
    op_d = op_q;
    rob_d = rob_q;
    q1_d = q1_q;
    q2_d = q2_q;
    v1_d = v1_q;
    v2_d = v2_q;
    issue_valid_d = issue_valid_q;
    issue_op_d = issue_op_q;
    issue_rob_id_d = issue_rob_id_q;
    issue_v1_d = issue_v1_q;
    issue_v2_d = issue_v2_q;
    if (rdy && flush) begin
      busy_d = '0;
      issue_valid_d = 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        {p1_d[i], v1_d[i]} = wake(p1_q[i], q1_q[i], v1_q[i]);
        {p2_d[i], v2_d[i]} = wake(p2_q[i], q2_q[i], v2_q[i]);
      end
      issue_valid_d = sel_found;
      if (sel_found) begin
        busy_d[sel_idx] = 1'b0;
        issue_op_d = op_q[sel_idx];
        issue_rob_id_d = rob_q[sel_idx];
        issue_v1_d = v1_q[sel_idx];
        issue_v2_d = v2_q[sel_idx];
      end
      if (dispatch_valid && free_found) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx] = dispatch_op;
        rob_d[free_idx] = dispatch_rob_id;
        q1_d[free_idx] = dispatch_q1;
        q2_d[free_idx] = dispatch_q2;
        {p1_d[free_idx], v1_d[free_idx]} = wake(dispatch_p1, dispatch_q1, dispatch_v1);
        {p2_d[free_idx], v2_d[free_idx]} = wake(dispatch_p2, dispatch_q2, dispatch_v2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      op_q <= '{default: '0};
      rob_q <= '{default: '0};
      q1_q <= '{default: '0};
      q2_q <= '{default: '0};
      v1_q <= '{default: '0};
      v2_q <= '{default: '0};
      issue_valid_q <= 1'b0;
      issue_op_q <= '0;
      issue_rob_id_q <= '0;
      issue_v1_q <= '0;
      issue_v2_q <= '0;
    end else begin
      busy_q <= busy_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      op_q <= op_d;
      rob_q <= rob_d;
      q1_q <= q1_d;
      q2_q <= q2_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      issue_valid_q <= issue_valid_d;
      issue_op_q <= issue_op_d;
      issue_rob_id_q <= issue_rob_id_d;
      issue_v1_q <= issue_v1_d;
      issue_v2_q <= issue_v2_d;
    end
  end
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed scenarios plus random traffic against a behavioural station model.
module tb_rs_alu;
  logic clk = 1'b0, rst_n, rdy, flush;
  logic dispatch_valid, dispatch_p1, dispatch_p2;
  logic [4:0] dispatch_op;
  logic [3:0] dispatch_rob_id, dispatch_q1, dispatch_q2;
  logic [31:0] dispatch_v1, dispatch_v2;
  logic cdb_alu_valid, cdb_lsb_valid;
  logic [3:0] cdb_alu_rob_id, cdb_lsb_rob_id;
  logic [31:0] cdb_alu_result, cdb_lsb_result;
  logic full, issue_valid;
  logic [4:0] issue_op;
  logic [3:0] issue_rob_id;
  logic [31:0] issue_v1, issue_v2;
  int checks = 0, errors = 0;

  typedef struct {
    logic busy, p1, p2;
    logic [4:0] op;
    logic [3:0] rob, q1, q2;
    logic [31:0] v1, v2;
  } ent_t;
  ent_t m [8];
  logic m_iv;
  logic [4:0] m_op;
  logic [3:0] m_rob;
  logic [31:0] m_v1, m_v2;

  rs_alu dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op), .dispatch_rob_id(dispatch_rob_id),
    .dispatch_v1(dispatch_v1), .dispatch_v2(dispatch_v2), .dispatch_p1(dispatch_p1), .dispatch_p2(dispatch_p2),
    .dispatch_q1(dispatch_q1), .dispatch_q2(dispatch_q2),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_id(cdb_alu_rob_id), .cdb_alu_result(cdb_alu_result),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_result(cdb_lsb_result),
    .full(full), .issue_valid(issue_valid), .issue_op(issue_op), .issue_rob_id(issue_rob_id),
    .issue_v1(issue_v1), .issue_v2(issue_v2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbusy();
    int n = 0;
    for (int i = 0; i < 8; i++) n += m[i].busy ? 1 : 0;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i] = '{default: '0};
    m_iv = 0; m_op = 0; m_rob = 0; m_v1 = 0; m_v2 = 0;
  endtask

  task automatic snoop(input logic p, input logic [3:0] q, input logic [31:0] v, output logic po, output logic [31:0] vo);
    po = p; vo = v;
    if (p && cdb_lsb_valid && cdb_lsb_rob_id == q) begin po = 0; vo = cdb_lsb_result; end
    if (p && cdb_alu_valid && cdb_alu_rob_id == q) begin po = 0; vo = cdb_alu_result; end
  endtask

  task automatic model_edge();
    int r = -1, f = -1;
    bit was_full;
    ent_t e;
    if (!rdy) return;
    if (flush) begin
      for (int i = 0; i < 8; i++) m[i].busy = 0;
      m_iv = 0;
      return;
    end
    was_full = nbusy() == 8;
    for (int i = 7; i >= 0; i--) begin
      if (m[i].busy && !m[i].p1 && !m[i].p2) r = i;
      if (!m[i].busy) f = i;
    end
    m_iv = r >= 0;
    if (r >= 0) begin
      m_op = m[r].op; m_rob = m[r].rob; m_v1 = m[r].v1; m_v2 = m[r].v2;
      m[r].busy = 0;
    end
    for (int i = 0; i < 8; i++) if (m[i].busy) begin
      snoop(m[i].p1, m[i].q1, m[i].v1, m[i].p1, m[i].v1);
      snoop(m[i].p2, m[i].q2, m[i].v2, m[i].p2, m[i].v2);
    end
    if (dispatch_valid && !was_full) begin
      e.busy = 1; e.op = dispatch_op; e.rob = dispatch_rob_id; e.q1 = dispatch_q1; e.q2 = dispatch_q2;
      snoop(dispatch_p1, dispatch_q1, dispatch_v1, e.p1, e.v1);
      snoop(dispatch_p2, dispatch_q2, dispatch_v2, e.p2, e.v2);
      m[f] = e;
    end
  endtask

  task automatic compare();
    chk("full", 32'(full), 32'(nbusy() == 8));
    chk("issue_valid", 32'(issue_valid), 32'(m_iv));
    chk("issue_op", 32'(issue_op), 32'(m_op));
    chk("issue_rob_id", 32'(issue_rob_id), 32'(m_rob));
    chk("issue_v1", issue_v1, m_v1);
    chk("issue_v2", issue_v2, m_v2);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    rdy = 1; flush = 0; dispatch_valid = 0; cdb_alu_valid = 0; cdb_lsb_valid = 0;
    dispatch_op = 0; dispatch_rob_id = 0; dispatch_v1 = 0; dispatch_v2 = 0;
    dispatch_p1 = 0; dispatch_p2 = 0; dispatch_q1 = 0; dispatch_q2 = 0;
    cdb_alu_rob_id = 0; cdb_alu_result = 0; cdb_lsb_rob_id = 0; cdb_lsb_result = 0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [3:0] rob, input logic [31:0] v1, input logic [31:0] v2,
                      input logic p1, input logic [3:0] q1, input logic p2, input logic [3:0] q2);
    dispatch_valid = 1; dispatch_op = op; dispatch_rob_id = rob; dispatch_v1 = v1; dispatch_v2 = v2;
    dispatch_p1 = p1; dispatch_q1 = q1; dispatch_p2 = p2; dispatch_q2 = q2;
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    rst_n = 1;
    // Ready dispatch issues one edge later and frees its entry
    disp(5'h00, 4'd3, 32'd5, 32'd7, 0, 0, 0, 0);
    tick(); chk("s1_latency", 32'(issue_valid), 0);
    idle(); tick();
    chk("s1_iv", 32'(issue_valid), 1); chk("s1_rob", 32'(issue_rob_id), 3);
    chk("s1_v1", issue_v1, 5); chk("s1_v2", issue_v2, 7);
    tick(); chk("s1_freed", 32'(issue_valid), 0);
    // Wakeup from ALU CDB
    disp(5'h08, 4'd2, 32'hdead, 32'd1, 1, 4'd6, 0, 0); tick();
    idle(); tick();
    cdb_alu_valid = 1; cdb_alu_rob_id = 6; cdb_alu_result = 32'h10; tick();
    chk("s2_wake_latency", 32'(issue_valid), 0);
    idle(); tick();
    chk("s2_iv", 32'(issue_valid), 1); chk("s2_v1", issue_v1, 32'h10); chk("s2_rob", 32'(issue_rob_id), 2);
    // Fill, drop, free one
    for (int i = 0; i < 8; i++) begin disp(5'h07, 4'(i), 0, 32'(i), 1, 4'd9, 0, 0); tick(); end
    chk("s3_full", 32'(full), 1);
    disp(5'h01, 4'd15, 1, 2, 0, 0, 0, 0); tick();
    idle(); cdb_alu_valid = 1; cdb_alu_rob_id = 9; cdb_alu_result = 32'h99; tick();
    chk("s3_still_full", 32'(full), 1);
    idle(); tick();
    chk("s3_full_drop", 32'(full), 0); chk("s3_first", 32'(issue_rob_id), 0);
    disp(5'h02, 4'd14, 3, 4, 0, 0, 0, 0); tick();
    chk("s3_accepted", 32'(nbusy()), 7);
    idle(); repeat (10) tick();
    // Dispatch bypass from LSB CDB
    disp(5'h04, 4'd8, 32'h1, 32'h0, 0, 0, 1, 4'd4);
    cdb_lsb_valid = 1; cdb_lsb_rob_id = 4; cdb_lsb_result = 32'hab; tick();
    idle(); tick();
    chk("s4_iv", 32'(issue_valid), 1); chk("s4_v2", issue_v2, 32'hab);
    // Priority order and flush
    for (int i = 0; i < 6; i++) begin
      disp(5'h06, 4'(i), 32'(i), 0, 1, (i == 1 || i == 5) ? 4'd13 : 4'd12, 0, 0); tick();
    end
    idle(); cdb_alu_valid = 1; cdb_alu_rob_id = 13; cdb_alu_result = 32'h55;
    cdb_lsb_valid = 1; cdb_lsb_rob_id = 13; cdb_lsb_result = 32'h66; tick();
    idle(); tick();
    chk("s5_first", 32'(issue_rob_id), 1); chk("s5_alu_prio", issue_v1, 32'h55);
    tick(); chk("s5_second", 32'(issue_rob_id), 5);
    flush = 1; tick();
    chk("s5_flush_iv", 32'(issue_valid), 0); chk("s5_flush_full", 32'(full), 0);
    idle(); cdb_alu_valid = 1; cdb_alu_rob_id = 12; tick();
    idle(); tick(); chk("s5_gone", 32'(issue_valid), 0);
    // rdy low freezes everything
    disp(5'h05, 4'd7, 32'h70, 32'h71, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      rdy = 0; cdb_alu_valid = 1; cdb_alu_rob_id = 7; cdb_alu_result = 32'hff;
      disp(5'h03, 4'd9, 1, 1, 0, 0, 0, 0); tick();
      chk("s6_frozen", 32'(issue_valid), 0);
    end
    idle(); tick();
    chk("s6_iv", 32'(issue_valid), 1); chk("s6_rob", 32'(issue_rob_id), 7);
    tick(); chk("s6_no_disp", 32'(issue_valid), 0);
    // Asynchronous reset mid-operation
    for (int i = 0; i < 8; i++) begin disp(5'h00, 4'(i), 32'(i), 0, 1, 4'd2, 0, 0); tick(); end
    idle();
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_full", 32'(full), 0); chk("rst_iv", 32'(issue_valid), 0);
    chk("rst_rob", 32'(issue_rob_id), 0); chk("rst_v2", issue_v2, 0);
    @(negedge clk); rst_n = 1;
    cdb_alu_valid = 1; cdb_alu_rob_id = 2; tick();
    idle(); tick(); chk("rst_nothing", 32'(issue_valid), 0);
    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      rdy = $urandom_range(0, 9) != 0;
      flush = $urandom_range(0, 49) == 0;
      dispatch_valid = $urandom_range(0, 1);
      dispatch_op = 5'($urandom); dispatch_rob_id = 4'($urandom);
      dispatch_v1 = $urandom; dispatch_v2 = $urandom;
      dispatch_p1 = $urandom_range(0, 1); dispatch_p2 = $urandom_range(0, 1);
      dispatch_q1 = 4'($urandom_range(0, 3)); dispatch_q2 = 4'($urandom_range(0, 3));
      cdb_alu_valid = $urandom_range(0, 2) == 0; cdb_alu_rob_id = 4'($urandom_range(0, 3)); cdb_alu_result = $urandom;
      cdb_lsb_valid = $urandom_range(0, 2) == 0; cdb_lsb_rob_id = 4'($urandom_range(0, 3)); cdb_lsb_result = $urandom;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
